// File: rtl/jt6295_rom_serve_if.sv
// Bundles the request ports of jt6295_rom_serve: control and channel
// requesters (cs/addr -> data/ok) and the external ROM byte port.
interface jt6295_rom_serve_if #(
    parameter int CH = 4
);
    logic              ctrl_cs;
    logic [9:0]        ctrl_addr;
    logic [7:0]        ctrl_data;
    logic              ctrl_ok;

    logic [CH-1:0]     ch_cs;
    logic [18*CH-1:0]  ch_addr;
    logic [8*CH-1:0]   ch_data;
    logic [CH-1:0]     ch_ok;

    logic              ext_cs;
    logic [17:0]       ext_addr;
    logic [7:0]        ext_data;
    logic              ext_ok;

    // slave: the ROM server itself
    modport slave (
        input  ctrl_cs, ctrl_addr, ch_cs, ch_addr, ext_data, ext_ok,
        output ctrl_data, ctrl_ok, ch_data, ch_ok, ext_cs, ext_addr
    );

    // master: requesters plus the external memory bridge
    modport master (
        output ctrl_cs, ctrl_addr, ch_cs, ch_addr, ext_data, ext_ok,
        input  ctrl_data, ctrl_ok, ch_data, ch_ok, ext_cs, ext_addr
    );
endinterface

// File: rtl/jt6295_rom_serve.sv
// Serves the JT6295 control and channel ROM ports from one external byte port,
// keeping a one-byte buffer per port so repeated reads hit without a new access.
module jt6295_rom_serve #(
    parameter int CH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    jt6295_rom_serve_if.slave        bus
);
    localparam int NP   = CH + 1;   // channels 0..CH-1, control port at index CH
    localparam int CTRL = CH;
    localparam int GW   = 3;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t            state_reg, state_next;
    logic              ext_cs_reg, ext_cs_next;
    logic [17:0]       ext_addr_reg, ext_addr_next;
    logic [GW-1:0]     grant_reg, grant_next;
    logic [1:0]        rr_reg, rr_next;

    logic [17:0]       buf_addr_reg [NP];
    logic [17:0]       buf_addr_next [NP];
    logic [7:0]        buf_data_reg [NP];
    logic [7:0]        buf_data_next [NP];
    logic [NP-1:0]     buf_vld_reg, buf_vld_next;

    logic [17:0]       port_addr [NP];
    logic [NP-1:0]     port_cs;
    logic [NP-1:0]     hit;
    logic [NP-1:0]     pend;

    logic              arb_found;
    logic [GW-1:0]     arb_id;

    function automatic logic [GW-1:0] wrap_ch(input int v);
        return GW'(v % CH);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            assign port_addr[gi]           = bus.ch_addr[18*gi +: 18];
            assign port_cs[gi]             = bus.ch_cs[gi];
            assign bus.ch_data[8*gi +: 8]  = buf_data_reg[gi];
            assign bus.ch_ok[gi]           = port_cs[gi] & hit[gi];
        end

        // ok is purely combinational so an address change drops it in the same cycle
        for (gi = 0; gi < NP; gi++) begin : g_hit
            assign hit[gi]  = buf_vld_reg[gi] && (buf_addr_reg[gi] == port_addr[gi]);
            assign pend[gi] = port_cs[gi] && !hit[gi];
        end
    endgenerate

    assign port_addr[CTRL] = {8'd0, bus.ctrl_addr};
    assign port_cs[CTRL]   = bus.ctrl_cs;
    assign bus.ctrl_data   = buf_data_reg[CTRL];
    assign bus.ctrl_ok     = bus.ctrl_cs & hit[CTRL];
    assign bus.ext_cs      = ext_cs_reg;
    assign bus.ext_addr    = ext_addr_reg;

    // Control port always wins; channels are searched upward from rr
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        if (pend[CTRL]) begin
            arb_found = 1'b1;
            arb_id    = GW'(CTRL);
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (!arb_found && pend[wrap_ch(int'(rr_reg) + i)]) begin
                    arb_found = 1'b1;
                    arb_id    = wrap_ch(int'(rr_reg) + i);
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        ext_cs_next   = ext_cs_reg;
        ext_addr_next = ext_addr_reg;
        grant_next    = grant_reg;
        rr_next       = rr_reg;
        buf_addr_next = buf_addr_reg;
        buf_data_next = buf_data_reg;
        buf_vld_next  = buf_vld_reg;

        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    ext_cs_next   = 1'b1;
                    ext_addr_next = port_addr[arb_id];
                    grant_next    = arb_id;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                // The fill is stored for the address that was fetched, even if the
                // requester has since moved on; a moved address simply misses.
                if (bus.ext_ok) begin
                    buf_data_next[grant_reg] = bus.ext_data;
                    buf_addr_next[grant_reg] = ext_addr_reg;
                    buf_vld_next[grant_reg]  = 1'b1;
                    ext_cs_next              = 1'b0;
                    state_next               = IDLE;
                    if (grant_reg != GW'(CTRL)) begin
                        rr_next = 2'(wrap_ch(int'(grant_reg) + 1));
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // flush wins over a coincident fill: the data lands but is not trusted
        if (flush) begin
            buf_vld_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_cs_reg   <= 1'b0;
            ext_addr_reg <= '0;
            grant_reg    <= '0;
            rr_reg       <= '0;
            buf_vld_reg  <= '0;
            for (int i = 0; i < NP; i++) begin
                buf_addr_reg[i] <= '0;
                buf_data_reg[i] <= '0;
            end
        end else begin
            ext_cs_reg   <= ext_cs_next;
            ext_addr_reg <= ext_addr_next;
            grant_reg    <= grant_next;
            rr_reg       <= rr_next;
            buf_vld_reg  <= buf_vld_next;
            buf_addr_reg <= buf_addr_next;
            buf_data_reg <= buf_data_next;
        end
    end
endmodule

// File: tb/tb_jt6295_rom_serve.sv
// Scoreboard bench for jt6295_rom_serve: stimulus queues expected external
// addresses and port responses; a monitor pops and compares on DUT events.
module tb_jt6295_rom_serve;
    localparam int CH = 4;
    localparam int NP = CH + 1;

    logic clk;
    logic rst_n;
    logic flush;

    jt6295_rom_serve_if #(.CH(CH)) bus ();

    jt6295_rom_serve #(.CH(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [7:0] data;
    } rsp_t;

    logic [17:0] exp_ext [$];
    rsp_t        exp_rsp [$];

    int n_checks = 0;
    int n_pass   = 0;
    int ext_seen = 0;

    logic mem_en      = 1'b1;
    int   mem_lat     = 1;
    logic flush_on_ok = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [17:0] a);
        return (a[7:0] + 8'hFB) ^ a[17:10];
    endfunction

    function automatic logic ok_of(input int p);
        return (p == CH) ? bus.ctrl_ok : bus.ch_ok[p];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rsp(input int p, input logic [7:0] d);
        rsp_t r;
        r.port = p;
        r.data = d;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_ok(input int p, input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ok_of(p)) break;
        end
        check(name, 32'(ok_of(p)), 32'd1);
    endtask

    task automatic wait_ext_cs(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ext_cs) break;
        end
        check(name, 32'(bus.ext_cs), 32'd1);
    endtask

    task automatic wait_ext_ok(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ext_ok) break;
        end
        check(name, 32'(bus.ext_ok), 32'd1);
    endtask

    // External memory: answers ext_cs after mem_lat cycles with a one-cycle ext_ok
    initial begin
        int cnt;
        cnt          = 0;
        bus.ext_ok   = 1'b0;
        bus.ext_data = 8'd0;
        flush        = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.ext_ok) begin
                bus.ext_ok = 1'b0;
                flush      = 1'b0;
                cnt        = 0;
            end else if (bus.ext_cs && mem_en) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.ext_data = mem_byte(bus.ext_addr);
                    bus.ext_ok   = 1'b1;
                    if (flush_on_ok) begin
                        flush       = 1'b1;
                        flush_on_ok = 1'b0;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: each new external request and each rising port ok pops the scoreboard
    initial begin
        logic          prev_cs;
        logic [NP-1:0] prev_ok;
        logic [NP-1:0] cur_ok;
        logic [17:0]   ea;
        rsp_t          r;
        logic [7:0]    d;
        prev_cs = 1'b0;
        prev_ok = '0;
        forever begin
            @(negedge clk);
            cur_ok = {bus.ctrl_ok, bus.ch_ok};
            if (bus.ext_cs && !prev_cs) begin
                ext_seen++;
                if (exp_ext.size() == 0) begin
                    n_checks++;
                    $display("FAIL ext_unexpected: got addr %0h expected no request", bus.ext_addr);
                end else begin
                    ea = exp_ext.pop_front();
                    check("ext_addr", 32'(bus.ext_addr), 32'(ea));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (cur_ok[p] && !prev_ok[p]) begin
                    d = (p == CH) ? bus.ctrl_data : bus.ch_data[8*p +: 8];
                    if (exp_rsp.size() == 0) begin
                        n_checks++;
                        $display("FAIL rsp_unexpected: got port %0d data %0h expected none", p, d);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_port", 32'(p), 32'(r.port));
                        check("rsp_data", 32'(d), 32'(r.data));
                    end
                end
            end
            prev_cs = bus.ext_cs;
            prev_ok = cur_ok;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst_n         = 1'b0;
        bus.ctrl_cs   = 1'b0;
        bus.ctrl_addr = '0;
        bus.ch_cs     = '0;
        bus.ch_addr   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ext_cs",    32'(bus.ext_cs),    32'd0);
        check("rst_ext_addr",  32'(bus.ext_addr),  32'd0);
        check("rst_ctrl_ok",   32'(bus.ctrl_ok),   32'd0);
        check("rst_ctrl_data", 32'(bus.ctrl_data), 32'd0);
        check("rst_ch_ok",     32'(bus.ch_ok),     32'd0);
        check("rst_ch_data",   bus.ch_data,        32'd0);
        step();
        rst_n = 1'b1;

        // Single control miss, memory answers after 2 cycles
        step();
        mem_lat = 2;
        exp_ext.push_back(18'h00008);
        push_rsp(CH, 8'h03);
        bus.ctrl_addr = 10'h008;
        bus.ctrl_cs   = 1'b1;
        wait_ext_ok("t1_ext_ok");
        check("t1_ext_addr",  32'(bus.ext_addr), 32'h00008);
        check("t1_ok_early",  32'(bus.ctrl_ok),  32'd0);
        @(negedge clk);
        check("t1_ctrl_ok",   32'(bus.ctrl_ok),   32'd1);
        check("t1_ctrl_data", 32'(bus.ctrl_data), 32'h03);

        // Phrase-style sweep of addresses 0..7
        mem_lat = 1;
        base = ext_seen;
        for (int a = 0; a < 8; a++) begin
            step();
            bus.ctrl_addr = 10'(a);
            exp_ext.push_back(18'(a));
            push_rsp(CH, mem_byte(18'(a)));
            @(negedge clk);
            check("t2_ok_drop", 32'(bus.ctrl_ok), 32'd0);
            wait_ok(CH, "t2_ok");
        end
        step();
        bus.ctrl_cs = 1'b0;
        @(negedge clk);
        check("t2_ext_count", 32'(ext_seen - base), 32'd8);

        // Everyone at once: ctrl, then channels from rr=0
        step();
        bus.ctrl_addr = 10'h100;
        bus.ch_addr   = {18'h30303, 18'h12345, 18'h10101, 18'h00404};
        exp_ext.push_back(18'h00100);
        exp_ext.push_back(18'h00404);
        exp_ext.push_back(18'h10101);
        exp_ext.push_back(18'h12345);
        exp_ext.push_back(18'h30303);
        push_rsp(CH, mem_byte(18'h00100));
        push_rsp(0,  mem_byte(18'h00404));
        push_rsp(1,  mem_byte(18'h10101));
        push_rsp(2,  mem_byte(18'h12345));
        push_rsp(3,  mem_byte(18'h30303));
        bus.ctrl_cs = 1'b1;
        bus.ch_cs   = 4'hF;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ctrl_ok && bus.ch_ok == 4'hF) break;
        end
        check("t3_all_ok", 32'({bus.ctrl_ok, bus.ch_ok}), 32'h1F);
        step();
        bus.ctrl_cs = 1'b0;
        bus.ch_cs   = 4'h0;

        // rr wrapped to 0 after ch3: ch1 before ch3
        step();
        bus.ch_addr[18*1 +: 18] = 18'h21111;
        bus.ch_addr[18*3 +: 18] = 18'h23333;
        exp_ext.push_back(18'h21111);
        exp_ext.push_back(18'h23333);
        push_rsp(1, mem_byte(18'h21111));
        push_rsp(3, mem_byte(18'h23333));
        bus.ch_cs = 4'b1010;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ch_ok == 4'b1010) break;
        end
        check("t3_rr_ok", 32'(bus.ch_ok), 32'hA);
        step();
        bus.ch_cs = 4'h0;

        // Buffered re-read on ch2 hits in the same cycle
        step();
        push_rsp(2, mem_byte(18'h12345));
        bus.ch_cs = 4'b0100;
        @(negedge clk);
        check("t4_hit_ok",     32'(bus.ch_ok[2]), 32'd1);
        check("t4_hit_ext_cs", 32'(bus.ext_cs),   32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_access",  32'(bus.ext_cs),   32'd0);
        step();
        bus.ch_cs = 4'h0;

        // ch0 moves its address while its fetch is in flight
        step();
        mem_lat = 4;
        bus.ch_addr[18*0 +: 18] = 18'h00AAA;
        exp_ext.push_back(18'h00AAA);
        bus.ch_cs = 4'b0001;
        wait_ext_cs("t5_ext_cs");
        step();
        bus.ch_addr[18*0 +: 18] = 18'h00BBB;
        exp_ext.push_back(18'h00BBB);
        push_rsp(0, mem_byte(18'h00BBB));
        wait_ext_ok("t5_ext_ok");
        check("t5_ok_during", 32'(bus.ch_ok[0]), 32'd0);
        @(negedge clk);
        check("t5_ok_after_old", 32'(bus.ch_ok[0]), 32'd0);
        check("t5_old_data",     32'(bus.ch_data[7:0]), 32'(mem_byte(18'h00AAA)));
        wait_ok(0, "t5_new_ok");
        step();
        bus.ch_cs = 4'h0;
        mem_lat = 1;

        // flush coincident with ext_ok: fill not trusted, request re-issued
        step();
        flush_on_ok = 1'b1;
        bus.ch_addr[18*1 +: 18] = 18'h30001;
        exp_ext.push_back(18'h30001);
        exp_ext.push_back(18'h30001);
        push_rsp(1, mem_byte(18'h30001));
        bus.ch_cs = 4'b0010;
        wait_ok(1, "t6_ok");
        step();
        bus.ch_cs = 4'h0;

        // flush also invalidated the ch2 buffer
        step();
        exp_ext.push_back(18'h12345);
        push_rsp(2, mem_byte(18'h12345));
        bus.ch_cs = 4'b0100;
        @(negedge clk);
        check("t6_ch2_flushed", 32'(bus.ch_ok[2]), 32'd0);
        wait_ok(2, "t6_ch2_ok");
        step();
        bus.ch_cs = 4'h0;

        // Reset while waiting drops ext_cs without a clock edge
        step();
        mem_en = 1'b0;
        bus.ctrl_addr = 10'h3FF;
        exp_ext.push_back(18'h003FF);
        bus.ctrl_cs = 1'b1;
        wait_ext_cs("t7_ext_cs");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_async_ext_cs",   32'(bus.ext_cs),   32'd0);
        check("t7_async_ext_addr", 32'(bus.ext_addr), 32'd0);
        @(negedge clk);
        check("t7_ctrl_ok", 32'(bus.ctrl_ok), 32'd0);
        step();
        bus.ctrl_cs = 1'b0;
        rst_n  = 1'b1;
        mem_en = 1'b1;

        repeat (4) @(negedge clk);
        check("end_ext_queue", 32'(exp_ext.size()), 32'd0);
        check("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
